// File: rtl/mod_cnt_rr_sched.sv
// Round-robin scheduler time-sharing one programmable modulo counter among NREQ requesters.
// Optional pause input enabled by defining SCHED_PAUSE_EN.
module mod_cnt_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   period,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     abort,
    output logic                busy,
    output logic [W-1:0]        q
`ifdef SCHED_PAUSE_EN
    ,
    input  logic                pause
`endif
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = OW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [W-1:0]    period_q, period_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    per_arr [NREQ];
    logic [CW-1:0]   pick_c;
    logic            win_found_c;
    logic [OW-1:0]   win_idx_c;
    logic [OW-1:0]   next_ptr_c;
    logic [W-1:0]    term_c;
    logic            pause_c;

`ifdef SCHED_PAUSE_EN
    assign pause_c = pause;
`else
    assign pause_c = 1'b0;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_per
        assign per_arr[i] = period[i*W +: W];
    end

    // First requester at or after ptr, wrapping modulo NREQ; returns {found, index}.
    function automatic logic [CW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                  input logic [OW-1:0]   ptr);
        logic [CW-1:0] res;
        logic [CW-1:0] cand;
        res = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = CW'(ptr) + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (r[cand[OW-1:0]]) begin
                res = {1'b1, cand[OW-1:0]};
            end
        end
        return res;
    endfunction

    assign pick_c      = pick_winner(req, rr_q);
    assign win_found_c = pick_c[OW];
    assign win_idx_c   = pick_c[OW-1:0];
    assign next_ptr_c  = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
    // Period 0 wraps to an all-ones terminal count, i.e. 2^W counts.
    assign term_c      = period_q - W'(1);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        period_d = period_q;
        cnt_d    = '0;
        grant_d  = '0;
        done_d   = '0;
        abort_d  = '0;
        busy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d  = RUN;
                    owner_d  = win_idx_c;
                    period_d = per_arr[win_idx_c];
                    grant_d  = NREQ'(1) << win_idx_c;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    abort_d = NREQ'(1) << owner_q;
                    rr_d    = next_ptr_c;
                end else if (pause_c) begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q;
                end else if (cnt_q == term_c) begin
                    state_d = DONE;
                    done_d  = NREQ'(1) << owner_q;
                    rr_d    = next_ptr_c;
                end else begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = busy_q;
    assign q     = cnt_q;

endmodule

// File: doc/mod_cnt_rr_sched.md
Name: mod_cnt_rr_sched

Overview:
- Round-robin scheduler that time-shares one programmable modulo counter between NREQ requesters.
- Each requester asks for an interval of its own length. The block grants one requester, runs the shared counter for that requester's period, then pulses done to that requester.
- It is the control layer above the free-running modulo counter used elsewhere in the binary_counter tree.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, counter and period width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; must be held high until done or abort.
- period  input  NREQ*W  flattened periods; requester i uses bits [i*W+W-1 : i*W].
- grant  output  NREQ  one-hot; high for the requester currently owning the counter.
- done  output  NREQ  one-hot, one-cycle pulse when the granted interval completes.
- abort  output  NREQ  one-hot, one-cycle pulse when the granted requester drops req early.
- busy  output  1  high while in RUN.
- q  output  W  shared counter value; 0 when not in RUN.
- pause  input  1  present only with SCHED_PAUSE_EN.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE, rr pointer=0, latched period=0, latched owner=0.
  - grant=0, done=0, abort=0, busy=0, q=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- Arbitration happens in IDLE only:
  - Search req starting at the rr pointer, wrapping modulo NREQ.
  - The first set bit wins.
  - Latch the owner index and that requester's period.
  - Go to RUN.
- IDLE with req=0: stay in IDLE; outputs stay 0.
- First RUN cycle (one cycle after the req sample): grant[owner]=1, busy=1, q=0.
- RUN: q increments by 1 each cycle.
- Terminal count: when q == P-1 (P = latched period), the next state is DONE.
- P=0 means 2^W counts: terminal at q=2^W-1, i.e. W-bit wrap of P-1.
- P=1: one RUN cycle with q=0.
- DONE (one cycle):
  - done[owner]=1, grant=0, busy=0, q=0.
  - rr pointer = (owner+1) mod NREQ.
  - Next state IDLE.
- Timing from req sampled in IDLE at cycle t:
  - grant rises at t+1.
  - done pulses at t+P+1.
  - The earliest next grant is at t+P+3.
- Abort: if req[owner]=0 during RUN, the next cycle has abort[owner]=1, grant=0, busy=0, q=0, state=IDLE, rr pointer=(owner+1) mod NREQ.
- No done pulse is produced for an aborted interval.
- period inputs are sampled only at arbitration; changes during RUN are ignored.
- Requests from non-owners during RUN are ignored until the next IDLE. Nothing is queued beyond the level req.
- The owner re-requesting immediately after done loses priority to any other active requester.
- At most one bit of grant, done and abort is ever set. done and abort are never set in the same cycle.

Optional Feature:
- Macro: SCHED_PAUSE_EN.
- Defined:
  - The pause input exists.
  - pause=1 in RUN holds q and the state, keeps grant and busy high, and suppresses terminal detection.
  - Abort detection stays active while paused.
  - pause has no effect in IDLE or DONE.
- Undefined: there is no pause port and the counter advances every RUN cycle.

Test Plan:
- Reset: assert reset mid-RUN (q=5, grant=0010) -> same cycle grant=0, q=0, busy=0. After release with req=0, outputs stay 0.
- Single interval: req=0001, period0=4 at cycle t -> grant=0001 during t+1..t+4 with q=0,1,2,3. At t+5, done=0001, grant=0. Back in IDLE at t+6.
- Round-robin fairness: req=1111 held, all periods=2 -> grant order 0001, 0010, 0100, 1000, 0001. Exactly one done per interval. No gaps other than DONE plus IDLE (2 cycles).
- Boundary periods:
  - period=1 -> one RUN cycle with q=0, then done.
  - period=0 with W=8 -> q runs 0..255 (256 RUN cycles), then done.
- Abort: owner 2 with period=10 drops req when q=3 -> next cycle abort=0100, no done. The next grant goes to requester 3 if requesting, else 0.
- Pause (SCHED_PAUSE_EN): period=5, pause high for 3 cycles at q=2 -> q holds at 2 for 3 cycles and done is delayed by exactly 3 cycles. The build without the macro still compiles and passes the other scenarios.
